// File: rtl/systolic_skew_feeder_if.sv
// Load-side handshake bundle for the systolic skew feeder: one A column and
// one B row per accepted beat.
interface systolic_skew_feeder_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] a_col_in;
    logic [N*W-1:0] b_row_in;

    modport master (output in_valid, output a_col_in, output b_row_in, input in_ready);
    modport slave  (input in_valid, input a_col_in, input b_row_in, output in_ready);
endinterface

// File: rtl/systolic_skew_feeder.sv
// Buffers one A/B tile pair and streams it diagonally skewed into an NxN
// systolic tile, sequencing accumulator clear, PE enable and tile-done.
module systolic_skew_feeder #(
    parameter int N      = 4,
    parameter int K      = 4,
    parameter int W      = 8,
    parameter int PE_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    systolic_skew_feeder_if.slave  load,
    output logic [N*W-1:0]         row_out,
    output logic [N*W-1:0]         col_out,
    output logic                   acc_clr,
    output logic                   pe_en,
    output logic                   busy,
    output logic                   tile_done
);
    localparam int DRAIN_LEN = N - 1 + PE_LAT;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int TW = (K + N - 1 > 1) ? $clog2(K + N - 1) : 1;
    localparam int DW = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [TW-1:0] T_LAST = TW'(K + N - 2);
    localparam logic [DW-1:0] D_LAST = DW'(DRAIN_LEN - 1);

    typedef enum logic [1:0] {LOAD, STREAM, DRAIN, DONE} state_t;

    state_t        state;
    logic [KW-1:0] k_cnt;
    logic [TW-1:0] t_cnt;
    logic [DW-1:0] d_cnt;

    logic [W-1:0] a_buf [N][K];
    logic [W-1:0] b_buf [K][N];

    logic beat;
    assign beat = (state == LOAD) && load.in_valid;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
            k_cnt <= '0;
            t_cnt <= '0;
            d_cnt <= '0;
        end else begin
            case (state)
                LOAD: if (load.in_valid) begin
                    if (k_cnt == K_LAST) begin
                        state <= STREAM;
                        t_cnt <= '0;
                    end else begin
                        k_cnt <= k_cnt + 1'b1;
                    end
                end
                STREAM: if (enable) begin
                    if (t_cnt == T_LAST) begin
                        state <= DRAIN;
                        d_cnt <= '0;
                    end else begin
                        t_cnt <= t_cnt + 1'b1;
                    end
                end
                DRAIN: if (enable) begin
                    if (d_cnt == D_LAST) state <= DONE;
                    else                 d_cnt <= d_cnt + 1'b1;
                end
                DONE: begin
                    state <= LOAD;
                    k_cnt <= '0;
                end
                default: state <= LOAD;
            endcase
        end
    end

    // NOTE: operand buffers carry no reset; outputs are gated by state, and a
    // tile is always fully rewritten before it can be streamed.
    always_ff @(posedge clk) begin
        if (beat) begin
            for (int i = 0; i < N; i++) begin
                a_buf[i][k_cnt] <= load.a_col_in[i*W +: W];
                b_buf[k_cnt][i] <= load.b_row_in[i*W +: W];
            end
        end
    end

    // Lane i carries A[i][k] when t == k+i; lane j carries B[k][j] when t == k+j.
    // NOTE: outputs get a default before the loops so no latch is inferred.
    always_comb begin
        row_out = '0;
        col_out = '0;
        if (state == STREAM) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < K; k++) begin
                    if (t_cnt == TW'(k + i)) row_out[i*W +: W] = a_buf[i][k];
                    if (t_cnt == TW'(k + i)) col_out[i*W +: W] = b_buf[k][i];
                end
            end
        end
    end

    assign load.in_ready = (state == LOAD);
    assign acc_clr       = (state == STREAM) && (t_cnt == '0) && enable;
    assign pe_en         = enable && ((state == STREAM) || (state == DRAIN));
    assign busy          = (state != LOAD);
    assign tile_done     = (state == DONE);

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: reset, skew windows, load gaps,
// stalls, ignored beats, mid-tile reset and back-to-back tiles.
module tb_systolic_skew_feeder;
    localparam int N = 4;
    localparam int K = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic [N*W-1:0] row_out, col_out;
    logic           acc_clr, pe_en, busy, tile_done;

    systolic_skew_feeder_if #(.N(N), .W(W)) ld ();

    systolic_skew_feeder #(.N(N), .K(K), .W(W), .PE_LAT(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load      (ld),
        .row_out   (row_out),
        .col_out   (col_out),
        .acc_clr   (acc_clr),
        .pe_en     (pe_en),
        .busy      (busy),
        .tile_done (tile_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0]   am [N][K];
    logic [W-1:0]   bm [K][N];
    logic [N*W-1:0] cap_row [40];
    logic [N*W-1:0] cap_col [40];
    int             last_acc_cyc;

    function automatic logic [N*W-1:0] model_row(input int t);
        logic [N*W-1:0] r = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < K) r[i*W +: W] = am[i][t-i];
        return r;
    endfunction

    function automatic logic [N*W-1:0] model_col(input int t);
        logic [N*W-1:0] r = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < K) r[j*W +: W] = bm[t-j][j];
        return r;
    endfunction

    task automatic set_pattern(input logic [7:0] ba, input logic [7:0] bb);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) begin
                am[i][k] = ba + 8'(16 * i + k + 1);
                bm[k][i] = bb + 8'(16 * k + i);
            end
    endtask

    // Entered and left at a falling edge; beat k is accepted on the next rise.
    task automatic load_tile(input bit toggle);
        for (int k = 0; k < K; k++) begin
            ld.in_valid = 1'b1;
            for (int i = 0; i < N; i++) begin
                ld.a_col_in[i*W +: W] = am[i][k];
                ld.b_row_in[i*W +: W] = bm[k][i];
            end
            #1;
            checks++;
            if (ld.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL load_ready beat=%0d got %b exp 1", k, ld.in_ready);
            end
            @(negedge clk);
            if (toggle && k < K - 1) begin
                ld.in_valid = 1'b0;
                ld.a_col_in = $urandom;
                ld.b_row_in = $urandom;
                @(negedge clk);
            end
        end
        ld.in_valid = 1'b0;
    endtask

    // Walks one tile from its first STREAM cycle to the following LOAD cycle,
    // comparing every output each cycle against a cycle model.
    task automatic stream_and_check(input string tag, input int stall_at,
                                    input int stall_len, input bit garbage);
        int phase = 0, t = 0, d = 0, c = 0, dones = 0;
        bit en;
        logic [N*W-1:0] er, ec;
        while (c < 40) begin
            en = !(stall_at >= 0 && c >= stall_at && c < stall_at + stall_len);
            enable = en;
            ld.in_valid = garbage && (phase < 2);
            if (garbage) begin
                ld.a_col_in = $urandom;
                ld.b_row_in = $urandom;
            end
            #1;
            er = (phase == 0) ? model_row(t) : '0;
            ec = (phase == 0) ? model_col(t) : '0;
            cap_row[c] = row_out;
            cap_col[c] = col_out;
            checks += 7;
            if (row_out !== er) begin
                failures++; $display("FAIL %s row_out c=%0d got %h exp %h", tag, c, row_out, er);
            end
            if (col_out !== ec) begin
                failures++; $display("FAIL %s col_out c=%0d got %h exp %h", tag, c, col_out, ec);
            end
            if (acc_clr !== (phase == 0 && t == 0 && en)) begin
                failures++; $display("FAIL %s acc_clr c=%0d got %b", tag, c, acc_clr);
            end
            if (pe_en !== (en && phase < 2)) begin
                failures++; $display("FAIL %s pe_en c=%0d got %b", tag, c, pe_en);
            end
            if (tile_done !== (phase == 2)) begin
                failures++; $display("FAIL %s tile_done c=%0d got %b", tag, c, tile_done);
            end
            if (busy !== (phase < 3)) begin
                failures++; $display("FAIL %s busy c=%0d got %b", tag, c, busy);
            end
            if (ld.in_ready !== (phase == 3)) begin
                failures++; $display("FAIL %s in_ready c=%0d got %b", tag, c, ld.in_ready);
            end
            if (acc_clr === 1'b1) last_acc_cyc = cyc;
            if (tile_done === 1'b1) dones++;
            if (phase == 3) break;
            if (phase == 0) begin
                if (en) begin
                    if (t == K + N - 2) begin phase = 1; d = 0; end
                    else t++;
                end
            end else if (phase == 1) begin
                if (en) begin
                    if (d == N - 1) phase = 2;
                    else d++;
                end
            end else begin
                phase = 3;
            end
            @(negedge clk);
            c++;
        end
        enable = 1'b1;
        checks += 2;
        if (phase != 3) begin
            failures++; $display("FAIL %s timeout got phase %0d exp 3", tag, phase);
        end
        if (dones != 1) begin
            failures++; $display("FAIL %s done_count got %0d exp 1", tag, dones);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1;
        ld.in_valid = 1'b0; ld.a_col_in = '0; ld.b_row_in = '0;
        #2;
        checks += 3;
        if (row_out !== '0 || col_out !== '0) begin
            failures++; $display("FAIL reset_data got %h/%h exp 0", row_out, col_out);
        end
        if ({acc_clr, pe_en, busy, tile_done} !== 4'b0) begin
            failures++; $display("FAIL reset_ctrl got %b exp 0000", {acc_clr, pe_en, busy, tile_done});
        end
        if (ld.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got %b exp 1", ld.in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        set_pattern(8'h00, 8'h80);
        load_tile(1'b0);
        stream_and_check("basic", -1, 0, 1'b0);
        checks += 7;
        if (cap_row[0] !== 32'h0000_0001) begin
            failures++; $display("FAIL t0_row got %h exp 00000001", cap_row[0]);
        end
        if (cap_col[0][7:0] !== 8'h80) begin
            failures++; $display("FAIL t0_col0 got %h exp 80", cap_col[0][7:0]);
        end
        if (cap_row[3][23:16] !== 8'h22) begin
            failures++; $display("FAIL t3_row2 got %h exp 22", cap_row[3][23:16]);
        end
        if (cap_row[3][31:24] !== 8'h31) begin
            failures++; $display("FAIL t3_row3 got %h exp 31", cap_row[3][31:24]);
        end
        if (cap_col[3][15:8] !== 8'hA1) begin
            failures++; $display("FAIL t3_col1 got %h exp a1", cap_col[3][15:8]);
        end
        if (cap_row[6][31:24] !== 8'h34) begin
            failures++; $display("FAIL t6_row3 got %h exp 34", cap_row[6][31:24]);
        end
        if (cap_col[6][31:24] !== 8'hB3) begin
            failures++; $display("FAIL t6_col3 got %h exp b3", cap_col[6][31:24]);
        end
    endtask

    task automatic test_toggle_load();
        set_pattern(8'h00, 8'h80);
        load_tile(1'b1);
        stream_and_check("toggle", -1, 0, 1'b0);
    endtask

    task automatic test_stall();
        set_pattern(8'h00, 8'h80);
        load_tile(1'b0);
        stream_and_check("stall", 2, 3, 1'b0);
    endtask

    task automatic test_garbage();
        set_pattern(8'h00, 8'h80);
        load_tile(1'b0);
        stream_and_check("garbage", -1, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        set_pattern(8'h00, 8'h80);
        load_tile(1'b0);
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (row_out !== model_row(4)) begin
            failures++; $display("FAIL mid_t4_row got %h exp %h", row_out, model_row(4));
        end
        reset = 1'b1;
        #1;
        checks += 2;
        if (row_out !== '0 || col_out !== '0 || {acc_clr, pe_en, busy, tile_done} !== 4'b0) begin
            failures++;
            $display("FAIL mid_reset_out got %h/%h/%b exp zeros", row_out, col_out,
                     {acc_clr, pe_en, busy, tile_done});
        end
        if (ld.in_ready !== 1'b1) begin
            failures++; $display("FAIL mid_reset_ready got %b exp 1", ld.in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        set_pattern(8'h40, 8'hC0);
        load_tile(1'b0);
        stream_and_check("after_reset", -1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int first_acc;
        last_acc_cyc = -1;
        set_pattern(8'h00, 8'h80);
        load_tile(1'b0);
        stream_and_check("b2b_1", -1, 0, 1'b0);
        first_acc = last_acc_cyc;
        set_pattern(8'h40, 8'hC0);
        load_tile(1'b0);
        stream_and_check("b2b_2", -1, 0, 1'b0);
        checks++;
        if (last_acc_cyc - first_acc != 16) begin
            failures++; $display("FAIL b2b_period got %0d exp 16", last_acc_cyc - first_acc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_toggle_load();
        test_stall();
        test_garbage();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
